// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operand/result encoding for the mux and demux ends
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int SEL_W     = 2;
    localparam int NUM_SLOTS = 4;

    // Slot indices follow the IN_SEL encoding used by the operand multiplexer.
    typedef enum logic [SEL_W-1:0] {
        SLOT_A = 2'd0,
        SLOT_B = 2'd1,
        SLOT_C = 2'd2,
        SLOT_D = 2'd3
    } slot_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [2:0] popcount4(input logic [NUM_SLOTS-1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/alu_demux_slot.sv
// rtl/alu_demux_slot.sv - single-entry holding slot with EMPTY/FULL flag
module alu_demux_slot
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             can_accept_o
);

    slot_state_e      state_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (wr_en_i) begin
                        state_q <= SLOT_FULL;
                        data_q  <= data_i;
                    end
                end
                SLOT_FULL: begin
                    // A write here only happens when the consumer drains this same cycle.
                    if (wr_en_i) begin
                        data_q <= data_i;
                    end else if (rd_ready_i) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign data_o       = data_q;
    assign valid_o      = (state_q == SLOT_FULL);
    assign can_accept_o = (state_q == SLOT_EMPTY) || rd_ready_i;

endmodule

// File: rtl/alu_demultiplex.sv
// rtl/alu_demultiplex.sv - 1-to-4 ALU result demux with delivered-word counter
// Optional broadcast write (IN_BCAST) is enabled by defining ALU_DEMUX_BCAST_EN.
module alu_demultiplex
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     IN_DATA,
    input  logic [SEL_W-1:0]     IN_SEL,
    input  logic                 IN_VALID,
`ifdef ALU_DEMUX_BCAST_EN
    input  logic                 IN_BCAST,
`endif
    output logic                 IN_READY,
    output logic [WIDTH-1:0]     OUT_A,
    output logic [WIDTH-1:0]     OUT_B,
    output logic [WIDTH-1:0]     OUT_C,
    output logic [WIDTH-1:0]     OUT_D,
    output logic [NUM_SLOTS-1:0] OUT_VALID,
    input  logic [NUM_SLOTS-1:0] OUT_READY,
    output logic [CNT_W-1:0]     DLV_CNT
);

    logic [WIDTH-1:0]     slot_data [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [NUM_SLOTS-1:0] slot_can_accept;
    logic [NUM_SLOTS-1:0] wr_en;
    logic [NUM_SLOTS-1:0] deliver;
    logic                 accept;
    logic                 bcast;

`ifdef ALU_DEMUX_BCAST_EN
    assign bcast = IN_BCAST;
`else
    assign bcast = 1'b0;
`endif

    // Broadcast needs every slot free; otherwise only the selected slot matters.
    assign IN_READY = bcast ? (&slot_can_accept) : slot_can_accept[IN_SEL];
    assign accept   = IN_VALID && IN_READY;
    assign deliver  = slot_valid & OUT_READY;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        assign wr_en[k] = accept && (bcast || (IN_SEL == SEL_W'(k)));

        alu_demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .wr_en_i      (wr_en[k]),
            .data_i       (IN_DATA),
            .rd_ready_i   (OUT_READY[k]),
            .data_o       (slot_data[k]),
            .valid_o      (slot_valid[k]),
            .can_accept_o (slot_can_accept[k])
        );
    end

    assign OUT_A     = slot_data[SLOT_A];
    assign OUT_B     = slot_data[SLOT_B];
    assign OUT_C     = slot_data[SLOT_C];
    assign OUT_D     = slot_data[SLOT_D];
    assign OUT_VALID = slot_valid;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_sum;

    // One spare bit catches overflow so the counter clamps instead of wrapping.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + {{(CNT_W-2){1'b0}}, popcount4(deliver)};
        cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign DLV_CNT = cnt_q;

endmodule

// File: tb/tb_alu_demultiplex.sv
// tb/tb_alu_demultiplex.sv - directed self-checking bench for alu_demultiplex
module tb_alu_demultiplex;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_bcast;
    logic [3:0]  out_ready;
    logic        in_ready;
    logic        in_ready4;
    logic [7:0]  out_a, out_b, out_c, out_d;
    logic [7:0]  out_a4, out_b4, out_c4, out_d4;
    logic [3:0]  out_valid;
    logic [3:0]  out_valid4;
    logic [15:0] dlv_cnt;
    logic [3:0]  dlv_cnt4;

    int total;
    int bad;

    alu_demultiplex #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .IN_DATA(in_data), .IN_SEL(in_sel), .IN_VALID(in_valid),
`ifdef ALU_DEMUX_BCAST_EN
        .IN_BCAST(in_bcast),
`endif
        .IN_READY(in_ready), .OUT_A(out_a), .OUT_B(out_b), .OUT_C(out_c), .OUT_D(out_d),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .DLV_CNT(dlv_cnt)
    );

    alu_demultiplex #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .IN_DATA(in_data), .IN_SEL(in_sel), .IN_VALID(in_valid),
`ifdef ALU_DEMUX_BCAST_EN
        .IN_BCAST(in_bcast),
`endif
        .IN_READY(in_ready4), .OUT_A(out_a4), .OUT_B(out_b4), .OUT_C(out_c4), .OUT_D(out_d4),
        .OUT_VALID(out_valid4), .OUT_READY(out_ready), .DLV_CNT(dlv_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_data = 8'h00; in_sel = 2'b00; in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b exp=0000", out_valid); end
        total++; if ({out_a, out_b, out_c, out_d} !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=00000000", {out_a, out_b, out_c, out_d}); end
        total++; if (dlv_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", dlv_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data = 8'h3C; in_sel = 2'b10; in_valid = 1'b1; out_ready = 4'b0000;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_empty got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_c !== 8'h3C) begin bad++; $display("FAIL bp_out_c got=%h exp=3c", out_c); end
        total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL bp_valid got=%b exp=0100", out_valid); end
        in_data = 8'h77; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        in_sel = 2'b00;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_other got=%b exp=1", in_ready); end
        in_sel = 2'b10;
        step();
        total++; if (out_c !== 8'h3C || out_valid !== 4'b0100) begin bad++; $display("FAIL bp_hold got=%h/%b exp=3c/0100", out_c, out_valid); end
        out_ready = 4'b0100;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_drain got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        total++; if (out_c !== 8'h77 || out_valid !== 4'b0100) begin bad++; $display("FAIL bp_refill got=%h/%b exp=77/0100", out_c, out_valid); end
        total++; if (dlv_cnt !== 16'd1) begin bad++; $display("FAIL bp_cnt1 got=%0d exp=1", dlv_cnt); end
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        total++; if (out_valid !== 4'b0000 || dlv_cnt !== 16'd2) begin bad++; $display("FAIL bp_drain got=%b/%0d exp=0000/2", out_valid, dlv_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        do_reset();
        out_ready = 4'b1111; in_sel = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = words[i];
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
            step();
            total++; if (out_a !== words[i] || out_valid !== 4'b0001) begin bad++; $display("FAIL b2b_word%0d got=%h/%b exp=%h/0001", i, out_a, out_valid, words[i]); end
            total++; if (dlv_cnt !== 16'(i)) begin bad++; $display("FAIL b2b_cnt%0d got=%0d exp=%0d", i, dlv_cnt, i); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 4'b0000 || dlv_cnt !== 16'd3) begin bad++; $display("FAIL b2b_final got=%b/%0d exp=0000/3", out_valid, dlv_cnt); end
        out_ready = 4'b0000;
    endtask

    task automatic test_fill_drain();
        do_reset();
        out_ready = 4'b0000; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i); in_data = 8'hA0 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        total++; if ({out_a, out_b, out_c, out_d} !== 32'hA0A1A2A3) begin bad++; $display("FAIL fill_data got=%h exp=a0a1a2a3", {out_a, out_b, out_c, out_d}); end
        total++; if (out_valid !== 4'b1111 || dlv_cnt !== 16'd0) begin bad++; $display("FAIL fill_valid got=%b/%0d exp=1111/0", out_valid, dlv_cnt); end
        step();
        total++; if ({out_a, out_b, out_c, out_d} !== 32'hA0A1A2A3) begin bad++; $display("FAIL fill_stable got=%h exp=a0a1a2a3", {out_a, out_b, out_c, out_d}); end
        out_ready = 4'b0010;
        step();
        total++; if (out_valid !== 4'b1101 || dlv_cnt !== 16'd1) begin bad++; $display("FAIL fill_drain_b got=%b/%0d exp=1101/1", out_valid, dlv_cnt); end
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        total++; if (out_valid !== 4'b0000 || dlv_cnt !== 16'd4) begin bad++; $display("FAIL fill_drain_all got=%b/%0d exp=0000/4", out_valid, dlv_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_sel = 2'(i); in_data = 8'(i);
            step();
            if (i == 15) begin
                total++; if (dlv_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_reach got=%0d exp=15", dlv_cnt4); end
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        total++; if (dlv_cnt4 !== 4'hF) begin bad++; $display("FAIL sat_cnt4 got=%h exp=f", dlv_cnt4); end
        total++; if (dlv_cnt !== 16'd20) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=20", dlv_cnt); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_ready = 4'b0000; in_valid = 1'b1;
        in_sel = 2'b01; in_data = 8'hB1; step();
        in_sel = 2'b11; in_data = 8'hD3; step();
        in_valid = 1'b0;
        total++; if (out_valid !== 4'b1010) begin bad++; $display("FAIL mid_pre got=%b exp=1010", out_valid); end
        out_ready = 4'b1111;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 4'b0000 || out_b !== 8'h00 || out_d !== 8'h00) begin bad++; $display("FAIL mid_async got=%b/%h/%h exp=0000/00/00", out_valid, out_b, out_d); end
        total++; if (dlv_cnt !== 16'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_cnt got=%0d/%b exp=0/1", dlv_cnt, in_ready); end
        step();
        rst = 1'b0;
        step();
        total++; if (dlv_cnt !== 16'd0) begin bad++; $display("FAIL mid_uncounted got=%0d exp=0", dlv_cnt); end
        out_ready = 4'b0000;
    endtask

`ifdef ALU_DEMUX_BCAST_EN
    task automatic test_bcast();
        do_reset();
        in_sel = 2'b01; in_data = 8'h55; in_bcast = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_bcast = 1'b0;
        total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL bc_valid got=%b exp=1111", out_valid); end
        total++; if ({out_a, out_b, out_c, out_d} !== 32'h55555555) begin bad++; $display("FAIL bc_data got=%h exp=55555555", {out_a, out_b, out_c, out_d}); end
        out_ready = 4'b0001; in_bcast = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_ready got=%b exp=0", in_ready); end
        in_bcast = 1'b0; out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        total++; if (dlv_cnt !== 16'd4) begin bad++; $display("FAIL bc_cnt got=%0d exp=4", dlv_cnt); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_fill_drain();
        test_saturate();
        test_reset_midop();
`ifdef ALU_DEMUX_BCAST_EN
        test_bcast();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_demultiplex.md
# alu_demultiplex

Registered 1-to-4 result demultiplexer: the return path of the ALU operand multiplexer. One ALU result word arrives with a 2-bit destination select and is steered into one of four single-entry holding slots (A, B, C, D), each drained by its consumer over an independent valid/ready handshake. It sits between the ALU output and the four operand/writeback consumers. It also counts delivered words for debug.

## Interface
- WIDTH, 8, data width of input and every output slot
- CNT_W, 16, width of the delivered-word counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- IN_DATA  input  WIDTH  result word from the ALU
- IN_SEL  input  2  destination: 00→A, 01→B, 10→C, 11→D
- IN_VALID  input  1  IN_DATA/IN_SEL valid
- IN_READY  output  1  block can accept this cycle
- OUT_A, OUT_B, OUT_C, OUT_D  output  WIDTH  slot contents
- OUT_VALID  output  4  per-slot full flag; bit 0 = A … bit 3 = D
- OUT_READY  input  4  per-slot consumer ready; same bit order
- DLV_CNT  output  CNT_W  saturating count of words delivered on any slot

## Operation
- Each slot is a two-state FSM: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
- Input accept: IN_VALID && IN_READY on a rising edge.
- IN_READY = slot[IN_SEL] EMPTY, or slot[IN_SEL] FULL and OUT_READY[IN_SEL]=1 (same-cycle drain and refill). IN_READY depends combinationally on IN_SEL and OUT_READY. It never depends on IN_VALID.
- Delivery on slot k: OUT_VALID[k] && OUT_READY[k] on a rising edge.
- Slot transitions:
  - EMPTY→FULL on accept to it.
  - FULL→EMPTY on delivery without accept.
  - FULL→FULL with new data on simultaneous delivery + accept.
  - FULL holds otherwise.
- A FULL slot's data and valid stay stable until delivered.
- Unselected slots are never written.
- The four slots drain independently. Any subset may deliver in the same cycle.
- DLV_CNT increments by the number of deliveries in the cycle (0–4). It saturates at 2^CNT_W−1 and never wraps.
- IN_SEL values are all legal. There is no error state.

## Timing
- Reset (async assert, synchronous-release by upstream):
  - OUT_VALID=4'b0000
  - OUT_A..OUT_D=0
  - DLV_CNT=0
  - IN_READY=1, since all slots are EMPTY
- Reset mid-operation discards all held words. They are not counted.
- Latency: a word accepted at edge n is visible on OUT_x with OUT_VALID set after edge n. The earliest delivery is edge n+1.
- Throughput: one word per cycle to any one slot, including back-to-back to the same slot when its consumer holds OUT_READY high.
- Back-pressure: while slot[IN_SEL] is FULL and its OUT_READY=0, IN_READY=0. The input holds. Other slots keep draining.

## Configuration
- ALU_DEMUX_BCAST_EN defined:
  - Adds input port IN_BCAST (1 bit).
  - An accept with IN_BCAST=1 writes IN_DATA into all four slots, ignoring IN_SEL.
  - IN_READY for broadcast requires every slot to be EMPTY or delivering that cycle.
  - Broadcast still counts four separate deliveries as each slot drains.
- ALU_DEMUX_BCAST_EN undefined:
  - IN_BCAST is absent.
  - Behaviour is strictly single-destination as above.

## Structure
- Shared package alu_pkg holds:
  - ALU_WIDTH=8
  - SEL_W=2
  - NUM_SLOTS=4
  - enum of slot indices SLOT_A..SLOT_D matching IN_SEL encoding
- The operand multiplexer uses the same package, so both ends agree on the encoding.
- Sub-module alu_demux_slot contains:
  - one WIDTH-bit holding register plus its EMPTY/FULL flag
  - inputs: wr_en, data, rd_ready
  - outputs: data, valid, can_accept
  - Instantiated four times.
- The top level holds select decode, IN_READY logic, and the popcount-saturating DLV_CNT.

## Test plan
- Reset then idle → OUT_VALID=0000, all OUT_x=0, DLV_CNT=0, IN_READY=1.
- Write 8'h3C with SEL=10, OUT_READY=0000 → next cycle OUT_C=8'h3C, OUT_VALID=0100. A second write to SEL=10 sees IN_READY=0 and holds until OUT_READY[2]=1.
- OUT_READY=1111, stream 8'h01,8'h02,8'h03 to SEL=00 on consecutive cycles → one word per cycle on OUT_A, no bubbles, DLV_CNT=3.
- Fill A,B,C,D with 8'hA0..8'hA3, then OUT_READY=1111 for one cycle → OUT_VALID=0000, DLV_CNT=4. Values are unchanged until delivery.
- CNT_W=4: deliver 20 words → DLV_CNT sticks at 4'hF.
- Assert rst while slots B and D are FULL → outputs clear immediately without a clock edge. No delivery is counted. With ALU_DEMUX_BCAST_EN, broadcast 8'h55 → OUT_VALID=1111, all OUT_x=8'h55.
